// File: rtl/counter_74xx_pkg.sv
// Shared definitions for the 74xx-style counter family.
//   DefaultWidth : default counter/preset width in bits
//   MaxWidth     : widest counter the helpers support
//   count_sel_e  : which source feeds the count register on the next edge
//   all_ones()   : reset value (2^width - 1), returned right-aligned in MaxWidth bits
package counter_74xx_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned MaxWidth     = 64;

  typedef enum logic [1:0] {
    SelClr,
    SelLoad,
    SelDec,
    SelHold
  } count_sel_e;

  function automatic logic [MaxWidth-1:0] all_ones(input int unsigned width);
    logic [MaxWidth-1:0] val;
    val = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width) begin
        val[i] = 1'b1;
      end
    end
    return val;
  endfunction

endpackage

// File: rtl/counter_7440103.sv
// Presettable down counter with synchronous clear, parallel load/enable and terminal count.
//   clk  : clock, all state changes on the rising edge
//   clr  : synchronous active-high clear, sets q to all ones
//   pl_n : synchronous parallel load, active-low, highest priority after clr
//   pe_n : synchronous parallel enable, active-low, loads p (not gated by te_n)
//   te_n : terminal enable, active-low, enables decrement and tc_n
//   p    : preset value
//   q    : registered count
//   tc_n : terminal count, active-low, low when q == 0 and te_n == 0
module counter_7440103
  import counter_74xx_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pl_n,
  input  logic             pe_n,
  input  logic             te_n,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic             tc_n
);

  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] count_q, count_d;
  count_sel_e       sel;

  // Priority select: clear, then either load strobe, then decrement, else hold.
  always_comb begin
    sel = SelHold;
    if (clr) begin
      sel = SelClr;
    end else if (!pl_n || !pe_n) begin
      sel = SelLoad;
    end else if (!te_n) begin
      sel = SelDec;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (sel)
      SelClr:  count_d = ResetVal;
      SelLoad: count_d = p;
      // Unsigned wrap: 0 - 1 gives all ones.
      SelDec:  count_d = count_q - WIDTH'(1);
      SelHold: count_d = count_q;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign q    = count_q;
  assign tc_n = ~((count_q == '0) && !te_n);

endmodule

// File: tb/tb_counter_7440103.sv
// Self-checking bench for counter_7440103 (WIDTH = 8): directed scenarios, an exhaustive
// load-to-terminal-count sweep, and randomized stimulus against a behavioural model.
module tb_counter_7440103;

  logic       clk;
  logic       clr;
  logic       pl_n;
  logic       pe_n;
  logic       te_n;
  logic [7:0] p;
  logic [7:0] q;
  logic       tc_n;

  int n_checks = 0;
  int n_errors = 0;
  int model_q  = 0;

  counter_7440103 #(
    .WIDTH(8)
  ) dut (
    .clk (clk),
    .clr (clr),
    .pl_n(pl_n),
    .pe_n(pe_n),
    .te_n(te_n),
    .p   (p),
    .q   (q),
    .tc_n(tc_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_tc_n(input int cnt, input logic te);
    return (cnt == 0 && te == 1'b0) ? 0 : 1;
  endfunction

  // Drive inputs away from the edge, clock once, advance the model, then compare.
  task automatic cycle(input logic c, input logic pl, input logic pe, input logic te,
                       input logic [7:0] pv, input string tag);
    @(negedge clk);
    clr  = c;
    pl_n = pl;
    pe_n = pe;
    te_n = te;
    p    = pv;
    @(posedge clk);
    if (c) model_q = 255;
    else if (!pl || !pe) model_q = int'(pv);
    else if (!te) model_q = (model_q + 255) % 256;
    #1;
    check_val({tag, ".q"}, int'(q), model_q);
    check_val({tag, ".tc_n"}, int'(tc_n), exp_tc_n(model_q, te));
  endtask

  initial begin
    int k;
    clr = 1'b0; pl_n = 1'b1; pe_n = 1'b1; te_n = 1'b1; p = 8'h00;

    // Reset, full count down to zero, wrap.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, "rst");
    check_val("rst_q_ff", int'(q), 255);
    for (int i = 0; i < 255; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "rst_cnt");
    check_val("rst_cnt_zero", int'(q), 0);
    check_val("rst_cnt_tc", int'(tc_n), 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "rst_wrap");
    check_val("rst_wrap_ff", int'(q), 255);

    // Parallel enable load then countdown.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, "pe_load");
    check_val("pe_load_5", int'(q), 5);
    for (int i = 4; i >= 0; i--) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "tc_cnt");
      check_val("tc_cnt_val", int'(q), i);
      check_val("tc_cnt_tc", int'(tc_n), (i == 0) ? 0 : 1);
    end

    // Priority: both loads with te_n active, then clr over load.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, "prio_load");
    check_val("prio_load_3c", int'(q), 8'h3C);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, "prio_clr");
    check_val("prio_clr_ff", int'(q), 255);

    // Enable gating.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, "gate_load");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'd0, "gate_hold");
    check_val("gate_hold_7", int'(q), 7);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, "gate_zero");
    check_val("gate_zero_tc", int'(tc_n), 1);
    @(negedge clk);
    pl_n = 1'b1;
    te_n = 1'b0;
    #1;
    check_val("gate_comb_tc", int'(tc_n), 0);

    // Exhaustive load-to-terminal-count latency.
    for (int pv = 0; pv < 256; pv++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'(pv), "ex_load");
      k = 0;
      while (tc_n === 1'b1 && k < 300) begin
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "ex_cnt");
        k++;
      end
      check_val("ex_latency", k, pv);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "ex_wrap");
      check_val("ex_wrap_ff", int'(q), 255);
    end

    // Mid-count reset and resume.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd100, "mid_load");
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "mid_cnt");
    check_val("mid_q60", int'(q), 60);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "mid_clr");
    check_val("mid_clr_ff", int'(q), 255);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "mid_res1");
    check_val("mid_res_fe", int'(q), 254);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, "mid_res2");
    check_val("mid_res_fd", int'(q), 253);

    // Randomized stimulus against the model.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) != 0),
            ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_7440103.md
COUNTER_7440103 -- requirements
Module: counter_7440103

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high: clk is the clock, clr is the reset.
REQ-002 Parameter: WIDTH, default 8, counter and preset width in bits.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 clr  input  1  synchronous active-high reset.
REQ-005 pl_n  input  1  synchronous parallel load, active-low, high priority.
REQ-006 pe_n  input  1  synchronous parallel enable, active-low, low priority.
REQ-007 te_n  input  1  terminal enable, active-low; gates both counting and tc_n.
REQ-008 p  input  WIDTH  preset value.
REQ-009 q  output  WIDTH  current count, registered.
REQ-010 tc_n  output  1  terminal count, active-low, combinational from q and te_n.

Function
REQ-011 Per rising clk edge, q SHALL be updated by the first matching row below, in priority order.
REQ-012 clr=1: q becomes all ones (2^WIDTH-1).
REQ-013 clr=0 and pl_n=0: q becomes p.
REQ-014 clr=0, pl_n=1 and pe_n=0: q becomes p. This row is not gated by te_n.
REQ-015 clr=0, pl_n=1, pe_n=1 and te_n=0: q becomes q-1 modulo 2^WIDTH; from 0 it wraps to all ones.
REQ-016 clr=0, pl_n=1, pe_n=1 and te_n=1: q holds.
REQ-017 tc_n SHALL be 0 exactly when q==0 and te_n==0; otherwise it is 1. Terminal count therefore lasts one clock while counting.
REQ-018 Load-to-count latency: after a load of p, tc_n SHALL go low p clocks later (te_n=0, no further loads); the next edge then wraps q to all ones.
REQ-019 Loading p=0 SHALL assert tc_n in the same cycle the load takes effect, if te_n=0.
REQ-020 When pl_n=0 and pe_n=0 together, the load SHALL happen once and q SHALL equal p.
REQ-021 A clr or load coinciding with q==0 SHALL override the wrap; the reset or load value wins.
REQ-022 Arithmetic SHALL be unsigned WIDTH-bit with no carry-out. Inputs are assumed synchronous to clk and are not synchronised internally.

Reset
REQ-023 While clr=1 at an edge, q SHALL be all ones after that edge, and tc_n SHALL be 1.
REQ-024 Before the first clr edge, q is undefined; the bench SHALL NOT check it.
REQ-025 A clr asserted mid-count SHALL abort the count at the next edge.
REQ-026 After clr deasserts, counting SHALL resume from all ones at the first edge with te_n=0.

Structure
REQ-027 Shared package counter_74xx_pkg SHALL hold the default WIDTH constant and the all-ones reset-value function. Other 74xx counters reuse the package.
REQ-028 The block SHALL be a single module with one count register, a priority next-state mux and tc_n decode. No sub-module is instantiated.
REQ-029 Only q SHALL be a storage element. No latches, and no asynchronous paths from clr, pl_n or pe_n.

Verification
REQ-030 Reset: clr=1 for one edge -> q=8'hFF and tc_n=1; clr=0, te_n=0, 255 edges -> q=0 and tc_n=0; next edge -> q=8'hFF and tc_n=1.
REQ-031 Load and terminal count: p=8'd5 with pe_n=0 for one edge -> q=5; then te_n=0 -> q=4,3,2,1,0 on successive edges, tc_n=0 only at q=0.
REQ-032 Priority: p=8'h3C with pl_n=0, pe_n=0, te_n=0 -> q=8'h3C, no decrement; clr=1 with pl_n=0 -> q=8'hFF.
REQ-033 Enable gating: q=8'd7 with te_n=1 for 10 edges -> q stays 7 and tc_n=1; load p=0 with te_n=1 -> q=0 and tc_n=1; then te_n=0 -> tc_n=0 combinationally.
REQ-034 Exhaustive: for every p in 0..255, load, then count with te_n=0 -> tc_n asserts after exactly p edges, and the following edge gives q=8'hFF.
REQ-035 Mid-operation reset: load 8'd100, count 40 edges (q=60), assert clr -> q=8'hFF on the next edge, then the count resumes downward from 8'hFF.
